// File: rtl/mash_ncn_param_if.sv
// Sample-side bundle of the MASH noise-cancellation network: carry vector in,
// cancelled multi-level sample out.
interface mash_ncn_param_if #(
  parameter int P_ORDER = 3,
  parameter int P_OUT_W = 5
);
  logic                      i_en;
  logic [P_ORDER-1:0]        i_quantize;
  logic [2:0]                i_order_sel;
  logic signed [P_OUT_W-1:0] o_network;
  logic                      o_valid;
  logic                      o_primed;

  modport master (output i_en, i_quantize, i_order_sel,
                  input  o_network, o_valid, o_primed);
  modport slave  (input  i_en, i_quantize, i_order_sel,
                  output o_network, o_valid, o_primed);
endinterface

// File: rtl/mash_ncn_param.sv
// Parametrised MASH noise-cancellation network: Horner-form cascade of
// delay + differentiator stages with runtime order select and prime tracking.

// One cascade stage k: a_k = q_k[n-tap] + a_{k+1}[n] - a_{k+1}[n-1].
module mash_ncn_stage #(
  parameter int HW = 2,
  parameter int W  = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         clr,
  input  logic         step,
  input  logic         active,
  input  logic         q,
  input  logic [2:0]   tap,
  input  logic [W-1:0] a_up,
  output logic [W-1:0] a
);
  logic [HW-1:0] hist;
  logic [W-1:0]  up_prev;
  logic [HW:0]   tv;
  logic          qd;

  always_comb begin
    tv = {hist, q};
    qd = 1'b0;
    for (int d = 0; d <= HW; d++)
      if (tap == 3'(d)) qd = tv[d];
    // Modular arithmetic: every partial sum fits W signed bits for legal orders.
    a = active ? (W'(qd) + a_up - up_prev) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || clr) begin
      hist    <= '0;
      up_prev <= '0;
    end else if (step && active) begin
      hist    <= tv[HW-1:0];
      up_prev <= a_up;
    end
  end
endmodule

module mash_ncn_param #(
  parameter int P_ORDER = 3,
  parameter int P_OUT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mash_ncn_param_if.slave bus
);
  localparam int W  = P_ORDER + 1;
  localparam int HW = (P_ORDER > 1) ? P_ORDER - 1 : 1;

  if (P_ORDER < 1 || P_ORDER > 4) begin : g_bad_order
    $error("mash_ncn_param: P_ORDER must be 1..4");
  end
  if (P_OUT_W < P_ORDER + 1) begin : g_bad_width
    $error("mash_ncn_param: P_OUT_W must be >= P_ORDER+1");
  end

  logic [2:0]                  ord, req, pcnt, pcnt_n;
  logic                        chg, step;
  logic [P_ORDER:0][W-1:0]     a_v;
  logic [P_ORDER-1:0][2:0]     tap_v;
  logic [P_ORDER-1:0]          act_v;
  logic signed [P_OUT_W-1:0]   net_q;
  logic                        vld_q, prm_q;

  always_comb begin
    if (bus.i_order_sel == 3'd0)               req = 3'd1;
    else if (bus.i_order_sel > 3'(P_ORDER))    req = 3'(P_ORDER);
    else                                       req = bus.i_order_sel;
    chg    = (req != ord);
    step   = bus.i_en && !chg;
    pcnt_n = (pcnt == 3'd4) ? 3'd4 : pcnt + 3'd1;
    for (int g = 0; g < P_ORDER; g++) begin
      act_v[g] = (3'(g + 1) <= ord);
      tap_v[g] = ord - 3'(g + 1);
    end
  end

  assign a_v[P_ORDER] = '0;

  mash_ncn_stage #(.HW(HW), .W(W)) u_stage [P_ORDER-1:0] (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clr    (chg),
    .step   (step),
    .active (act_v),
    .q      (bus.i_quantize),
    .tap    (tap_v),
    .a_up   (a_v[P_ORDER:1]),
    .a      (a_v[P_ORDER-1:0])
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ord   <= 3'(P_ORDER);
      pcnt  <= '0;
      net_q <= '0;
      vld_q <= 1'b0;
      prm_q <= 1'b0;
    end else begin
      vld_q <= step;
      if (chg) begin
        // New order restarts the network; a same-cycle sample is dropped.
        ord   <= req;
        pcnt  <= '0;
        prm_q <= 1'b0;
      end else if (bus.i_en) begin
        pcnt  <= pcnt_n;
        prm_q <= (pcnt_n >= ord);
        net_q <= P_OUT_W'($signed(a_v[0]));
      end
    end
  end

  assign bus.o_network = net_q;
  assign bus.o_valid   = vld_q;
  assign bus.o_primed  = prm_q;
endmodule

// File: tb/tb_mash_ncn_param.sv
// Directed bench for mash_ncn_param: order-3 instance for the main cases,
// order-4 instance for the binomial and delay checks.
module tb_mash_ncn_param;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mash_ncn_param_if #(.P_ORDER(3), .P_OUT_W(5)) b3 ();
  mash_ncn_param_if #(.P_ORDER(4), .P_OUT_W(6)) b4 ();

  mash_ncn_param #(.P_ORDER(3), .P_OUT_W(5)) dut3 (.i_clk(clk), .i_rst(rst), .bus(b3));
  mash_ncn_param #(.P_ORDER(4), .P_OUT_W(6)) dut4 (.i_clk(clk), .i_rst(rst), .bus(b4));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic exp3(input string tag, input int net, input int vld, input int prm);
    int n;
    n = $signed(b3.o_network);
    chk({tag, ".net"}, n, net);
    chk({tag, ".vld"}, int'(b3.o_valid), vld);
    chk({tag, ".prm"}, int'(b3.o_primed), prm);
  endtask

  task automatic exp4(input string tag, input int net, input int vld, input int prm);
    int n;
    n = $signed(b4.o_network);
    chk({tag, ".net"}, n, net);
    chk({tag, ".vld"}, int'(b4.o_valid), vld);
    chk({tag, ".prm"}, int'(b4.o_primed), prm);
  endtask

  // Drive one cycle on the order-3 instance, sample 1 ns after the edge.
  task automatic cyc3(input logic en, input logic [2:0] q, input logic [2:0] sel);
    b3.i_en = en; b3.i_quantize = q; b3.i_order_sel = sel;
    b4.i_en = 1'b0; b4.i_quantize = '0; b4.i_order_sel = 3'd4;
    @(posedge clk); #1;
  endtask

  task automatic cyc4(input logic en, input logic [3:0] q);
    b4.i_en = en; b4.i_quantize = q; b4.i_order_sel = 3'd4;
    b3.i_en = 1'b0; b3.i_quantize = '0; b3.i_order_sel = 3'd3;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b3.i_en = 1'b1; b3.i_quantize = (i % 2 == 0) ? 3'b111 : 3'b101; b3.i_order_sel = 3'd3;
      b4.i_en = 1'b1; b4.i_quantize = (i % 2 == 0) ? 4'b1111 : 4'b1001; b4.i_order_sel = 3'd4;
      @(posedge clk); #1;
      exp3("rst3", 0, 0, 0);
      exp4("rst4", 0, 0, 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    b3.i_en = 1'b0; b3.i_quantize = '0; b3.i_order_sel = 3'd3;
    b4.i_en = 1'b0; b4.i_quantize = '0; b4.i_order_sel = 3'd4;
    #1;

    // Reset behaviour and M=3 all-ones stream
    do_reset();
    cyc3(1, 3'b111, 3); exp3("ones0", 1, 1, 0);
    cyc3(1, 3'b111, 3); exp3("ones1", 0, 1, 0);
    cyc3(1, 3'b111, 3); exp3("ones2", 1, 1, 1);
    cyc3(1, 3'b111, 3); exp3("ones3", 1, 1, 1);
    cyc3(1, 3'b111, 3); exp3("ones4", 1, 1, 1);

    // Stage-3 impulse
    do_reset();
    cyc3(1, 3'b100, 3); exp3("imp3_0", 1, 1, 0);
    cyc3(1, 3'b000, 3); exp3("imp3_1", -2, 1, 0);
    cyc3(1, 3'b000, 3); exp3("imp3_2", 1, 1, 1);
    cyc3(1, 3'b000, 3); exp3("imp3_3", 0, 1, 1);
    cyc3(1, 3'b000, 3); exp3("imp3_4", 0, 1, 1);

    // Stage-1 impulse
    do_reset();
    cyc3(1, 3'b001, 3); exp3("imp1_0", 0, 1, 0);
    cyc3(1, 3'b000, 3); exp3("imp1_1", 0, 1, 0);
    cyc3(1, 3'b000, 3); exp3("imp1_2", 1, 1, 1);
    cyc3(1, 3'b000, 3); exp3("imp1_3", 0, 1, 1);

    // Stage-2 impulse
    do_reset();
    cyc3(1, 3'b010, 3); exp3("imp2_0", 0, 1, 0);
    cyc3(1, 3'b000, 3); exp3("imp2_1", 1, 1, 0);
    cyc3(1, 3'b000, 3); exp3("imp2_2", -1, 1, 1);
    cyc3(1, 3'b000, 3); exp3("imp2_3", 0, 1, 1);

    // Enable gaps: disabled cycles carry junk that must be ignored
    do_reset();
    cyc3(1, 3'b100, 3); exp3("gap0", 1, 1, 0);
    cyc3(0, 3'b111, 3); exp3("gap0h", 1, 0, 0);
    cyc3(0, 3'b111, 3); exp3("gap0h", 1, 0, 0);
    cyc3(1, 3'b000, 3); exp3("gap1", -2, 1, 0);
    cyc3(0, 3'b111, 3); exp3("gap1h", -2, 0, 0);
    cyc3(0, 3'b111, 3); exp3("gap1h", -2, 0, 0);
    cyc3(1, 3'b000, 3); exp3("gap2", 1, 1, 1);
    cyc3(0, 3'b111, 3); exp3("gap2h", 1, 0, 1);
    cyc3(0, 3'b111, 3); exp3("gap2h", 1, 0, 1);
    cyc3(1, 3'b000, 3); exp3("gap3", 0, 1, 1);

    // Order switch 3->2 mid-stream; stage-3 carries ignored at M=2
    do_reset();
    cyc3(1, 3'b111, 3); exp3("sw_pre0", 1, 1, 0);
    cyc3(1, 3'b111, 3); exp3("sw_pre1", 0, 1, 0);
    cyc3(1, 3'b111, 3); exp3("sw_pre2", 1, 1, 1);
    cyc3(1, 3'b010, 2); exp3("sw_drop", 1, 0, 0);
    cyc3(1, 3'b110, 2); exp3("sw_m2_0", 1, 1, 0);
    cyc3(1, 3'b100, 2); exp3("sw_m2_1", -1, 1, 1);
    cyc3(1, 3'b100, 2); exp3("sw_m2_2", 0, 1, 1);

    // Order clamp: 0 -> M=1, 7 -> M=P_ORDER
    cyc3(1, 3'b001, 0); exp3("clamp0_drop", 0, 0, 0);
    cyc3(1, 3'b001, 0); exp3("clamp0_m1", 1, 1, 1);
    cyc3(0, 3'b000, 7); exp3("clamp7_chg", 1, 0, 0);
    cyc3(1, 3'b100, 7); exp3("clamp7_m3", 1, 1, 0);

    // Order-4 instance: stage-4 impulse gives binomial row
    do_reset();
    cyc4(1, 4'b1000); exp4("m4imp0", 1, 1, 0);
    cyc4(1, 4'b0000); exp4("m4imp1", -3, 1, 0);
    cyc4(1, 4'b0000); exp4("m4imp2", 3, 1, 0);
    cyc4(1, 4'b0000); exp4("m4imp3", -1, 1, 1);
    cyc4(1, 4'b0000); exp4("m4imp4", 0, 1, 1);

    // Order-4: stage-1 all-ones appears after 3 samples
    do_reset();
    cyc4(1, 4'b0001); exp4("m4one0", 0, 1, 0);
    cyc4(1, 4'b0001); exp4("m4one1", 0, 1, 0);
    cyc4(1, 4'b0001); exp4("m4one2", 0, 1, 0);
    cyc4(1, 4'b0001); exp4("m4one3", 1, 1, 1);
    cyc4(1, 4'b0001); exp4("m4one4", 1, 1, 1);

    // Mid-stream reset overrides enable and order change
    cyc4(1, 4'b0001);
    rst = 1'b1;
    b4.i_en = 1'b1; b4.i_quantize = 4'b1111; b4.i_order_sel = 3'd2;
    @(posedge clk); #1;
    exp4("midrst", 0, 0, 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
